// File: rtl/sc_pkg.sv
// Shared types and constants for the MAROC slow-control sequencer.
package sc_pkg;

  localparam int          SC_FRAME_LEN = 829;
  localparam logic [15:0] CRC_POLY     = 16'h1021;
  localparam logic [15:0] CRC_INIT     = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RSTSC,
    ST_LOAD,
    ST_SHIFT,
    ST_CHECK,
    ST_FIN
  } sc_state_e;

  // One MSB-first CRC-16-CCITT step for a single serial bit.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    return {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/sc_sequencer_if.sv
// Handshake and serial-link bundle between the sequencer and its environment.
interface sc_sequencer_if;
  logic start;
  logic verify;
  logic D_SC;
  logic Q_SC;
  logic set_new_data;
  logic CK_SC;
  logic RST_SC_n;
  logic busy;
  logic done;
  logic err;

  modport master (
    output start, verify, D_SC, Q_SC,
    input  set_new_data, CK_SC, RST_SC_n, busy, done, err
  );

  modport slave (
    input  start, verify, D_SC, Q_SC,
    output set_new_data, CK_SC, RST_SC_n, busy, done, err
  );
endinterface

// File: rtl/sc_crc16.sv
// Bit-serial CRC-16-CCITT accumulator with synchronous clear to the init value.
module sc_crc16 import sc_pkg::*; (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  // clear has priority so a new sequence always starts from CRC_INIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   crc <= '0;
    else if (clr) crc <= CRC_INIT;
    else if (en)  crc <= crc16_step(crc, din);
  end

endmodule

// File: rtl/sc_sequencer.sv
// MAROC slow-control sequencer: resets the register, strobes the external
// transmitter, clocks the frame out, and optionally reads it back and compares
// CRCs of what was sent against what came back.
module sc_sequencer import sc_pkg::*; #(
  parameter int FRAME_LEN = SC_FRAME_LEN,
  parameter int HALF_DIV  = 4,
  parameter int RST_CYC   = 8
) (
  input  logic          CK_SYS,
  input  logic          RST_n,
  sc_sequencer_if.slave bus
);

  // one shared down-phase counter covers the reset hold and both LOAD halves
  localparam int CNT_MAX = (RST_CYC - 1 > 2 * HALF_DIV - 1) ? RST_CYC - 1 : 2 * HALF_DIV - 1;
  localparam int CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] RST_END  = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] H_END    = CW'(HALF_DIV - 1);
  localparam logic [CW-1:0] LOAD_END = CW'(2 * HALF_DIV - 1);
  localparam logic [9:0]    F_END    = 10'(FRAME_LEN);

  sc_state_e   state;
  logic [CW-1:0] cnt;
  logic [9:0]  bitcnt;
  logic        pass2;
  logic        ver_q;
  logic        ck_sc;
  logic        rst_sc_n;
  logic        snd;
  logic        busy;
  logic        done;
  logic        err;

  logic        rise_now;
  logic        crc_clr;
  logic [15:0] crc_tx;
  logic [15:0] crc_rx;

  // a rising CK_SC edge is produced on this cycle: sample the serial lines now
  assign rise_now = (state == ST_SHIFT) && (cnt == H_END) && !ck_sc;
  assign crc_clr  = (state == ST_IDLE) && bus.start;

  sc_crc16 u_crc_tx (
    .clk   (CK_SYS),
    .rst_n (RST_n),
    .clr   (crc_clr),
    .en    (rise_now && !pass2),
    .din   (bus.D_SC),
    .crc   (crc_tx)
  );

  sc_crc16 u_crc_rx (
    .clk   (CK_SYS),
    .rst_n (RST_n),
    .clr   (crc_clr),
    .en    (rise_now && pass2),
    .din   (bus.Q_SC),
    .crc   (crc_rx)
  );

  // sequencing FSM; every output is a register so CK_SC and the strobes are glitch-free
  always_ff @(posedge CK_SYS or negedge RST_n) begin
    if (!RST_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bitcnt   <= '0;
      pass2    <= 1'b0;
      ver_q    <= 1'b0;
      ck_sc    <= 1'b1;
      rst_sc_n <= 1'b1;
      snd      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state    <= ST_RSTSC;
            busy     <= 1'b1;
            err      <= 1'b0;
            ver_q    <= bus.verify;
            pass2    <= 1'b0;
            rst_sc_n <= 1'b0;
            cnt      <= '0;
          end
        end
        ST_RSTSC: begin
          if (cnt == RST_END) begin
            state    <= ST_LOAD;
            rst_sc_n <= 1'b1;
            snd      <= 1'b1;
            cnt      <= '0;
            bitcnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_LOAD: begin
          // strobe for the first half, quiet second half, CK_SC held high
          if (cnt == H_END) snd <= 1'b0;
          if (cnt == LOAD_END) begin
            state <= ST_SHIFT;
            ck_sc <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (cnt != H_END) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (!ck_sc) begin
              ck_sc  <= 1'b1;
              bitcnt <= bitcnt + 10'd1;
            end else if (bitcnt != F_END) begin
              ck_sc <= 1'b0;
            end else if (pass2) begin
              state <= ST_CHECK;
            end else if (ver_q) begin
              // readback pass reuses LOAD but skips the register reset
              state  <= ST_LOAD;
              pass2  <= 1'b1;
              snd    <= 1'b1;
              bitcnt <= '0;
            end else begin
              state <= ST_FIN;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
        ST_CHECK: begin
          state <= ST_FIN;
          err   <= (crc_rx != crc_tx);
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        ST_FIN: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.set_new_data = snd;
  assign bus.CK_SC        = ck_sc;
  assign bus.RST_SC_n     = rst_sc_n;
  assign bus.busy         = busy;
  assign bus.done         = done;
  assign bus.err          = err;

endmodule

// File: doc/sc_sequencer.md
SC_SEQUENCER -- requirements
Module: sc_sequencer

Interface
REQ-001 Parameter FRAME_LEN, default 829: serial frame length in bits.
REQ-002 Parameter HALF_DIV, default 4: CK_SYS cycles per CK_SC half-period, minimum 2.
REQ-003 Parameter RST_CYC, default 8: CK_SYS cycles RST_SC_n is held low before shifting.
REQ-004 CK_SYS  in  1  system clock; all logic on its rising edge.
REQ-005 RST_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to program the slow-control frame.
REQ-007 verify  in  1  sampled with start; 1 = add readback pass.
REQ-008 D_SC  in  1  serial data monitored from the frame transmitter.
REQ-009 Q_SC  in  1  serial readback from the MAROC slow-control register.
REQ-010 set_new_data  out  1  load strobe to the frame transmitter, high for HALF_DIV cycles.
REQ-011 CK_SC  out  1  serial clock to the transmitter and MAROC; idles high.
REQ-012 RST_SC_n  out  1  MAROC slow-control register reset, active low.
REQ-013 busy  out  1  high from accepted start until done.
REQ-014 done  out  1  one-cycle pulse at sequence end.
REQ-015 err  out  1  readback mismatch flag, valid with done, held until next accepted start.

Function
REQ-016 States SHALL be IDLE, RSTSC, LOAD, SHIFT, CHECK, FIN.
REQ-017 IDLE: start=1 SHALL go to RSTSC next cycle, set busy, clear err, latch verify, set pass=1.
REQ-018 start while busy=1 SHALL be ignored.
REQ-019 RSTSC: RST_SC_n=0 for exactly RST_CYC cycles, then LOAD; RSTSC SHALL be entered only on pass 1.
REQ-020 LOAD: set_new_data=1 for HALF_DIV cycles, then low for HALF_DIV cycles with CK_SC high throughout, then SHIFT.
REQ-021 SHIFT: CK_SC toggles every HALF_DIV cycles, first edge falling; exactly FRAME_LEN falling and FRAME_LEN rising edges, ending high.
REQ-022 Bit counter (10 bits) SHALL increment on each rising CK_SC edge; SHIFT exits when it reaches FRAME_LEN; counter clears on LOAD entry.
REQ-023 D_SC and Q_SC SHALL be sampled on the CK_SYS cycle that produces each rising CK_SC edge.
REQ-024 Pass 1: CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first) over sampled D_SC into crc_tx.
REQ-025 Pass 2: same CRC over sampled Q_SC into crc_rx; D_SC ignored.
REQ-026 End of SHIFT pass 1: verify=0 -> FIN; verify=1 -> pass=2, LOAD (no RSTSC).
REQ-027 End of SHIFT pass 2 -> CHECK: err set when crc_rx != crc_tx, one cycle, then FIN.
REQ-028 FIN: done=1 one cycle, busy=0 that same cycle, next state IDLE.
REQ-029 set_new_data and any CK_SC falling edge SHALL never be high/occur in the same cycle.
REQ-030 Total busy length (verify=0) SHALL be 1+RST_CYC+2*HALF_DIV+2*FRAME_LEN*HALF_DIV+1 cycles.

Reset
REQ-031 RST_n low, at any time including mid-SHIFT: state IDLE, CK_SC=1, RST_SC_n=1, set_new_data=0, busy=0, done=0, err=0, counters and CRCs cleared.
REQ-032 Reset release SHALL not generate a CK_SC edge or done pulse.

Structure
REQ-033 Package sc_pkg SHALL hold the state enum, CRC polynomial/init constants and FRAME_LEN default.
REQ-034 CRC update SHALL be one sub-module sc_crc16 (1-bit serial, enable, clear), instantiated twice.
REQ-035 Transmitter SHALL be external; this block contains no frame storage.

Verification
REQ-036 Reset then start, verify=0, defaults -> 829 falling/829 rising CK_SC edges, RST_SC_n low 8 cycles, done at cycle 6650, err=0.
REQ-037 verify=1, MAROC model = 829-bit shift register, frame 0x155 in DAC fields -> two passes, err=0, one done.
REQ-038 verify=1, model flips readback bit 400 -> err=1 at done, stays 1 until next start.
REQ-039 Second start pulse at bit 100 of SHIFT -> ignored, edge count still 829, one done.
REQ-040 RST_n low at bit 500 -> all outputs at reset values within the cycle; later start completes normally.
REQ-041 Check: no CK_SC falling edge while set_new_data=1; CK_SC high for whole LOAD phase.
